// File: rtl/psum_pkg.sv
// Shared types, default widths and arithmetic helpers for the partial-sum accumulator.
package psum_pkg;

  localparam int unsigned FILTER_NUM_DEF = 32;
  localparam int unsigned PSUM_W_DEF     = 8;
  localparam int unsigned ACC_W_DEF      = 16;
  localparam int unsigned MAX_COL_DEF    = 64;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned OUT_W          = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    DONE
  } state_t;

  // Signed add clamped to the range of a w-bit two's-complement accumulator.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

  // ReLU followed by clamp to the positive 8-bit range.
  function automatic logic [OUT_W-1:0] relu_sat(input logic signed [31:0] v);
    if (v < 32'sd0) begin
      return OUT_W'(0);
    end else if (v > 32'sd127) begin
      return OUT_W'(127);
    end
    return OUT_W'(v);
  endfunction

endpackage

// File: rtl/psum_accumulator_fifo.sv
// Small synchronous in-order FIFO holding finished output pixels.
module psum_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && (count != CNT_W'(DEPTH));
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates CCM partial sums across input-channel passes per output column,
// then applies ReLU/saturation and streams pixels out through a small FIFO.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int unsigned FILTER_NUM = FILTER_NUM_DEF,
  parameter int unsigned PSUM_W     = PSUM_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned MAX_COL    = MAX_COL_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [8:0]                   num_col,
  input  logic [7:0]                   num_pass,
  input  logic [8:0]                   num_row,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FILTER_NUM*PSUM_W-1:0] partial_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FILTER_NUM*OUT_W-1:0]  out_data,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned COL_W = $clog2(MAX_COL);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW    = FILTER_NUM * OUT_W;

  state_t state;
  state_t state_nxt;

  logic [8:0]             num_col_q;
  logic [7:0]             num_pass_q;
  logic [8:0]             num_row_q;
  logic [8:0]             col_cnt;
  logic [7:0]             pass_cnt;
  logic [8:0]             row_cnt;
  logic [COL_W-1:0]       col_idx;
  logic [CNT_W-1:0]       fifo_count;
  logic signed [ACC_W-1:0] acc   [MAX_COL][FILTER_NUM];
  logic signed [ACC_W-1:0] sum_v [FILTER_NUM];
  logic [DW-1:0]          push_data;
  logic start_ok, cfg_zero, first_pass, last_col, last_pass, last_row;
  logic beat, push, pop, layer_end;

  assign start_ok   = (state == IDLE) && start;
  assign cfg_zero   = (num_col == '0) || (num_pass == '0) || (num_row == '0);
  assign col_idx    = col_cnt[COL_W-1:0];
  assign first_pass = (pass_cnt == '0);
  assign last_col   = (col_cnt == num_col_q - 9'd1);
  assign last_pass  = (pass_cnt == num_pass_q - 8'd1);
  assign last_row   = (row_cnt == num_row_q - 9'd1);

  // Full check uses the registered count only; a pop this cycle does not free a slot.
  assign in_ready  = (state == ACC) && (!last_pass || (fifo_count < CNT_W'(FIFO_DEPTH)));
  assign beat      = in_valid && in_ready;
  assign push      = beat && last_pass;
  assign layer_end = beat && last_col && last_pass && last_row;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (state == ACC) || (state == DRAIN);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = cfg_zero ? DONE : ACC;
      ACC:     if (layer_end) state_nxt = DRAIN;
      DRAIN:   if (fifo_count == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch and column/pass/row counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_col_q  <= '0;
      num_pass_q <= '0;
      num_row_q  <= '0;
      col_cnt    <= '0;
      pass_cnt   <= '0;
      row_cnt    <= '0;
    end else if (start_ok) begin
      num_col_q  <= num_col;
      num_pass_q <= num_pass;
      num_row_q  <= num_row;
      col_cnt    <= '0;
      pass_cnt   <= '0;
      row_cnt    <= '0;
    end else if (beat) begin
      if (last_col) begin
        col_cnt <= '0;
        if (last_pass) begin
          pass_cnt <= '0;
          row_cnt  <= row_cnt + 9'd1;
        end else begin
          pass_cnt <= pass_cnt + 8'd1;
        end
      end else begin
        col_cnt <= col_cnt + 9'd1;
      end
    end
  end

  // Read-modify-write of the current column; pass 0 overwrites stale contents.
  always_comb begin : acc_update
    logic signed [31:0] psum_k;
    logic signed [31:0] acc_rd;
    push_data = '0;
    psum_k    = '0;
    acc_rd    = '0;
    for (int k = 0; k < int'(FILTER_NUM); k++) begin
      psum_k   = 32'($signed(partial_sum[k*PSUM_W +: PSUM_W]));
      acc_rd   = 32'(acc[col_idx][k]);
      sum_v[k] = first_pass ? ACC_W'(psum_k) : ACC_W'(sat_add(acc_rd, psum_k, ACC_W));
      push_data[k*OUT_W +: OUT_W] = relu_sat(32'(sum_v[k]));
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      for (int k = 0; k < int'(FILTER_NUM); k++) begin
        acc[col_idx][k] <= sum_v[k];
      end
    end
  end

  psum_out_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (out_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator (12-bit accumulators to reach saturation).
module tb_psum_accumulator;

  localparam int unsigned FN = 32;
  localparam int unsigned DW = FN * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [8:0]    num_col;
  logic [7:0]    num_pass;
  logic [8:0]    num_row;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] partial_sum;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  psum_accumulator #(
    .FILTER_NUM (FN),
    .PSUM_W     (8),
    .ACC_W      (12),
    .MAX_COL    (64),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_col     (num_col),
    .num_pass    (num_pass),
    .num_row     (num_row),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .partial_sum (partial_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic [7:0] in_v;
    logic [7:0] exp_v;
  } relu_vec_t;

  typedef struct {
    logic [8:0] ncol;
    logic [7:0] npass;
    logic [8:0] nrow;
  } cfg_vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < int'(FN); k++) r[k*8 +: 8] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [8:0] c, input logic [7:0] p, input logic [8:0] r);
    num_col  = c;
    num_pass = p;
    num_row  = r;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int waited;
    waited      = 0;
    partial_sum = d;
    in_valid    = 1'b1;
    while (!in_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!in_ready) check("beat_accept_timeout", DW'(in_ready), DW'(1));
    else step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int waited;
    waited = 0;
    while (!done && waited < 500) begin
      step();
      waited++;
    end
    check({name, "_done"}, DW'(done), DW'(1));
    check({name, "_busy_at_done"}, DW'(busy), DW'(0));
    step();
    check({name, "_done_pulse"}, DW'(done), DW'(0));
  endtask

  // Output scoreboard: every pop is compared in order against the expected queue.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected no output", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    relu_vec_t     relu_tbl [8];
    cfg_vec_t      zero_tbl [3];
    logic [DW-1:0] d;
    logic [DW-1:0] e;

    relu_tbl[0] = '{8'hFB, 8'd0};
    relu_tbl[1] = '{8'd100, 8'd100};
    relu_tbl[2] = '{8'd127, 8'd127};
    relu_tbl[3] = '{8'h80, 8'd0};
    relu_tbl[4] = '{8'd0, 8'd0};
    relu_tbl[5] = '{8'd1, 8'd1};
    relu_tbl[6] = '{8'hFF, 8'd0};
    relu_tbl[7] = '{8'd64, 8'd64};
    zero_tbl[0] = '{9'd1, 8'd1, 9'd0};
    zero_tbl[1] = '{9'd0, 8'd2, 9'd1};
    zero_tbl[2] = '{9'd3, 8'd0, 9'd2};

    rst = 1'b1; start = 1'b0; num_col = '0; num_pass = '0; num_row = '0;
    in_valid = 1'b0; partial_sum = '0; out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    rst = 1'b0;
    step();

    // Single pass, two columns: -5 clips to 0, 100 passes through.
    do_start(9'd2, 8'd1, 9'd1);
    check("sp_busy", DW'(busy), DW'(1));
    exp_q.push_back(fill(8'd0));
    exp_q.push_back(fill(8'd100));
    send_beat(fill(8'hFB));
    check("sp_latency_out_valid", DW'(out_valid), DW'(1));
    send_beat(fill(8'd100));
    wait_done("single_pass");

    // ReLU/saturation table, one column per row, single pass.
    do_start(9'd1, 8'd1, 9'd8);
    for (int i = 0; i < 8; i++) exp_q.push_back(fill(relu_tbl[i].exp_v));
    for (int i = 0; i < 8; i++) send_beat(fill(relu_tbl[i].in_v));
    wait_done("relu_table");

    // Three passes on one column.
    do_start(9'd1, 8'd3, 9'd1);
    e = '0; e[7:0] = 8'd127; e[15:8] = 8'd0; e[23:16] = 8'd39;
    exp_q.push_back(e);
    d = '0; d[7:0] = 8'd50; d[15:8] = 8'd10;  d[23:16] = 8'd20; send_beat(d);
    d = '0; d[7:0] = 8'd50; d[15:8] = 8'hE2;  d[23:16] = 8'd20; send_beat(d);
    d = '0; d[7:0] = 8'd50; d[15:8] = 8'd5;   d[23:16] = 8'hFF; send_beat(d);
    wait_done("three_pass");

    // 3 columns x 2 passes x 2 rows: col c row r -> filter0 = 20c+3+2r, filter1 = 55.
    do_start(9'd3, 8'd2, 9'd2);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        e = '0; e[7:0] = 8'(20*c + 3 + 2*r); e[15:8] = 8'd55;
        exp_q.push_back(e);
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 2; p++) begin
        for (int c = 0; c < 3; c++) begin
          d = '0; d[7:0] = 8'(10*c + 3*p + r); d[15:8] = (p == 0) ? 8'hFB : 8'd60;
          send_beat(d);
        end
      end
    end
    wait_done("multi_col");

    // Saturation at 12 bits: 17 x 127 clamps at 2047, 17 x -128 clamps at -2048.
    do_start(9'd1, 8'd17, 9'd1);
    e = '0; e[7:0] = 8'd127; e[15:8] = 8'd0; e[23:16] = 8'd17;
    exp_q.push_back(e);
    d = '0; d[7:0] = 8'd127; d[15:8] = 8'h80; d[23:16] = 8'd1;
    for (int i = 0; i < 17; i++) send_beat(d);
    wait_done("saturation");

    // Backpressure: FIFO fills after 4 beats, head holds, then all 8 drain in order.
    out_ready = 1'b0;
    do_start(9'd8, 8'd1, 9'd1);
    for (int i = 0; i < 8; i++) begin
      e = '0;
      for (int k = 0; k < int'(FN); k++) e[k*8 +: 8] = 8'(10*i + k);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 4; i++) send_beat(exp_q[i]);
    check("bp_in_ready_low", DW'(in_ready), DW'(0));
    check("bp_out_valid", DW'(out_valid), DW'(1));
    partial_sum = exp_q[4];
    in_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready_held_low", DW'(in_ready), DW'(0));
      check("bp_head_stable", out_data, exp_q[0]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      d = '0;
      for (int k = 0; k < int'(FN); k++) d[k*8 +: 8] = 8'(10*i + k);
      send_beat(d);
    end
    wait_done("backpressure");

    // Zero-config starts finish in one cycle without output.
    for (int i = 0; i < 3; i++) begin
      do_start(zero_tbl[i].ncol, zero_tbl[i].npass, zero_tbl[i].nrow);
      check("zero_done", DW'(done), DW'(1));
      check("zero_busy", DW'(busy), DW'(0));
      check("zero_out_valid", DW'(out_valid), DW'(0));
      step();
      check("zero_done_pulse", DW'(done), DW'(0));
    end

    // A start while busy is ignored: layer still ends after its 2 beats.
    do_start(9'd1, 8'd1, 9'd2);
    exp_q.push_back(fill(8'd5));
    exp_q.push_back(fill(8'd6));
    send_beat(fill(8'd5));
    do_start(9'd5, 8'd3, 9'd4);
    send_beat(fill(8'd6));
    wait_done("start_while_busy");

    // Reset mid-layer with a partly filled FIFO, then a clean layer over stale accumulators.
    out_ready = 1'b0;
    do_start(9'd2, 8'd2, 9'd2);
    send_beat(fill(8'd10)); send_beat(fill(8'd20));
    send_beat(fill(8'd1));  send_beat(fill(8'd2));
    send_beat(fill(8'd30)); send_beat(fill(8'd40));
    send_beat(fill(8'd100));
    check("pre_rst_out_valid", DW'(out_valid), DW'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_out_valid", DW'(out_valid), DW'(0));
    check("mid_rst_in_ready", DW'(in_ready), DW'(0));
    check("mid_rst_busy", DW'(busy), DW'(0));
    step();
    check("post_rst_out_valid", DW'(out_valid), DW'(0));
    out_ready = 1'b1;
    do_start(9'd2, 8'd2, 9'd1);
    exp_q.push_back(fill(8'd8));
    exp_q.push_back(fill(8'd10));
    send_beat(fill(8'd7)); send_beat(fill(8'd8));
    send_beat(fill(8'd1)); send_beat(fill(8'd2));
    wait_done("after_reset");

    check("all_outputs_seen", DW'(exp_q.size()), DW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
